// File: rtl/ct_split.sv
// Packet-aware 1-to-RADIX splitter: routes each packet to a latched destination subset through a one-entry output buffer.
// Latency: a beat accepted at cycle t is presented on o_valid/o_data at t+1; full throughput of one beat per cycle.
// Backpressure: o_ready drops while any pending sink is not ready this cycle; each sink drains independently.
module ct_split #(
    parameter int RADIX   = 2,
    parameter int WIDTH   = 1,
    parameter int EOP_LOC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic [RADIX-1:0] i_mask,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [RADIX-1:0] o_valid,
    input  logic [RADIX-1:0] i_ready
);

    // Packet framing states: waiting for a first beat, or inside a multi-beat packet.
    localparam logic [0:0] S_SOP = 1'b0;
    localparam logic [0:0] S_MID = 1'b1;

    logic [0:0]       state;
    logic [RADIX-1:0] pend;       // sinks that still owe an acceptance of the buffered beat
    logic [RADIX-1:0] lock_mask;  // route held for the body of the current packet
    logic [RADIX-1:0] eff_mask;
    logic [WIDTH-1:0] buf_data;
    logic             accept;
    logic             in_eop;

    // Buffer is free when every pending sink takes the beat this cycle; closed while in reset.
    always_comb begin
        o_ready  = !reset && ((pend & ~i_ready) == '0);
        accept   = i_valid && o_ready;
        in_eop   = i_data[EOP_LOC];
        eff_mask = (state == S_SOP) ? i_mask : lock_mask;
        o_valid  = pend;
        o_data   = buf_data;
    end

    // Output buffer: a new load replaces whatever drains this cycle; otherwise clear sinks that accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= '0;
            buf_data <= '0;
        end else if (accept) begin
            buf_data <= i_data;
            pend     <= eff_mask;
        end else begin
            pend     <= pend & ~i_ready;
        end
    end

    // Packet framing: latch the route on a non-EOP first beat, release it on the EOP beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_SOP;
            lock_mask <= '0;
        end else if (accept) begin
            if (state == S_SOP) begin
                if (!in_eop) begin
                    lock_mask <= i_mask;
                    state     <= S_MID;
                end
            end else begin
                if (in_eop) begin
                    state <= S_SOP;
                end
            end
        end
    end

endmodule

// File: tb/tb_ct_split.sv
module tb_ct_split;
    localparam int RADIX   = 4;
    localparam int WIDTH   = 8;
    localparam int EOP_LOC = 0;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic [RADIX-1:0] i_mask;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic [RADIX-1:0] o_valid;
    logic [RADIX-1:0] i_ready;

    int checks = 0;
    int errors = 0;

    ct_split #(.RADIX(RADIX), .WIDTH(WIDTH), .EOP_LOC(EOP_LOC)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_mask  (i_mask),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    // Reference model: per-sink queues of beats still owed, plus packet route tracking.
    logic [WIDTH-1:0] mq [RADIX][$];
    logic             in_pkt;
    logic [RADIX-1:0] pkt_mask;
    logic [RADIX-1:0] exp_valid;
    logic             exp_ready;
    logic [WIDTH-1:0] exp_data;

    function automatic logic [WIDTH-1:0] mk_beat(input logic eop);
        logic [WIDTH-1:0] d;
        d = WIDTH'($urandom());
        d[EOP_LOC] = eop;
        return d;
    endfunction

    // Drive inputs (called just after negedge) and derive model expectations for this cycle.
    task automatic sample(input logic [WIDTH-1:0] d, input logic v, input logic [RADIX-1:0] m,
                          input logic [RADIX-1:0] r);
        bit found;
        i_data = d; i_valid = v; i_mask = m; i_ready = r;
        #1;
        found = 0;
        exp_valid = '0;
        exp_data = '0;
        exp_ready = !reset;
        for (int k = 0; k < RADIX; k++) begin
            if (mq[k].size() != 0) begin
                exp_valid[k] = 1'b1;
                if (!found) exp_data = mq[k][0];
                found = 1;
                if (mq[k].size() > (r[k] ? 1 : 0)) exp_ready = 1'b0;
            end
        end
    endtask

    // Apply this cycle's handshakes to the model, then move to the next negedge.
    task automatic commit();
        logic [RADIX-1:0] route;
        if (reset) begin
            for (int k = 0; k < RADIX; k++) mq[k].delete();
            in_pkt = 0;
            pkt_mask = '0;
        end else begin
            for (int k = 0; k < RADIX; k++)
                if (i_ready[k] && mq[k].size() != 0) void'(mq[k].pop_front());
            if (i_valid && exp_ready) begin
                route = in_pkt ? pkt_mask : i_mask;
                if (!in_pkt && !i_data[EOP_LOC]) begin
                    in_pkt = 1;
                    pkt_mask = i_mask;
                end else if (in_pkt && i_data[EOP_LOC]) begin
                    in_pkt = 0;
                end
                for (int k = 0; k < RADIX; k++)
                    if (route[k]) mq[k].push_back(i_data);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sample('0, 1'b1, 4'b1111, 4'b1111);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_o_ready got %b want 0", o_ready); end
        checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL reset_o_valid got %b want 0000", o_valid); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_o_data got %h want 00", o_data); end
        commit();
        reset = 1'b0;
    endtask

    task automatic test_unicast();
        logic [WIDTH-1:0] sent [8];
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                sent[i] = mk_beat(1'b1);
                sample(sent[i], 1'b1, 4'b0100, 4'b1111);
            end else begin
                sample('0, 1'b0, 4'b0000, 4'b1111);
            end
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL unicast_ready beat %0d got %b want 1", i, o_ready); end
            if (i > 0) begin
                checks++; if (o_valid !== 4'b0100) begin errors++; $display("FAIL unicast_valid beat %0d got %b want 0100", i, o_valid); end
                checks++; if (o_data !== sent[i-1]) begin errors++; $display("FAIL unicast_data beat %0d got %h want %h", i, o_data, sent[i-1]); end
            end
            commit();
        end
    endtask

    task automatic test_packet_lock();
        logic [RADIX-1:0] mask_tab [5] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        logic             eop_tab  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [RADIX-1:0] want_tab [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic [WIDTH-1:0] sent [5];
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                sent[i] = mk_beat(eop_tab[i]);
                sample(sent[i], 1'b1, mask_tab[i], 4'b1111);
            end else begin
                sample('0, 1'b0, 4'b0000, 4'b1111);
            end
            if (i > 0) begin
                checks++; if (o_valid !== want_tab[i-1]) begin errors++; $display("FAIL lock_valid beat %0d got %b want %b", i-1, o_valid, want_tab[i-1]); end
                checks++; if (o_data !== sent[i-1]) begin errors++; $display("FAIL lock_data beat %0d got %h want %h", i-1, o_data, sent[i-1]); end
            end
            commit();
        end
    endtask

    task automatic test_staggered();
        logic [WIDTH-1:0] b;
        b = mk_beat(1'b1);
        sample(b, 1'b1, 4'b1111, 4'b0000);
        commit();
        sample('0, 1'b0, 4'b0000, 4'b0011);
        checks++; if (o_valid !== 4'b1111) begin errors++; $display("FAIL stagger_valid_t1 got %b want 1111", o_valid); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stagger_ready_t1 got %b want 0", o_ready); end
        commit();
        sample('0, 1'b0, 4'b0000, 4'b1100);
        checks++; if (o_valid !== 4'b1100) begin errors++; $display("FAIL stagger_valid_t2 got %b want 1100", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stagger_ready_t2 got %b want 1", o_ready); end
        checks++; if (o_data !== b) begin errors++; $display("FAIL stagger_data got %h want %h", o_data, b); end
        commit();
        sample('0, 1'b0, 4'b0000, 4'b1111);
        checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL stagger_once got %b want 0000", o_valid); end
        commit();
    endtask

    task automatic test_null_mask();
        logic [WIDTH-1:0] b;
        sample(mk_beat(1'b1), 1'b1, 4'b0000, 4'b1111);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL null_ready got %b want 1", o_ready); end
        commit();
        b = mk_beat(1'b1);
        sample(b, 1'b1, 4'b0001, 4'b1111);
        checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL null_valid got %b want 0000", o_valid); end
        commit();
        sample('0, 1'b0, 4'b0000, 4'b1111);
        checks++; if (o_valid !== 4'b0001) begin errors++; $display("FAIL null_next_valid got %b want 0001", o_valid); end
        checks++; if (o_data !== b) begin errors++; $display("FAIL null_next_data got %h want %h", o_data, b); end
        commit();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] b;
        b = mk_beat(1'b1);
        sample(b, 1'b1, 4'b0010, 4'b0000);
        commit();
        for (int i = 0; i < 5; i++) begin
            sample(mk_beat(1'b1), 1'b1, 4'b0100, 4'b0000);
            checks++; if (o_valid !== 4'b0010) begin errors++; $display("FAIL bp_valid cyc %0d got %b want 0010", i, o_valid); end
            checks++; if (o_data !== b) begin errors++; $display("FAIL bp_data cyc %0d got %h want %h", i, o_data, b); end
            checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc %0d got %b want 0", i, o_ready); end
            commit();
        end
        sample('0, 1'b0, 4'b0000, 4'b0010);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", o_ready); end
        commit();
        sample('0, 1'b0, 4'b0000, 4'b0000);
        checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL bp_done_valid got %b want 0000", o_valid); end
        commit();
    endtask

    task automatic test_reset_mid_packet();
        logic [WIDTH-1:0] b;
        sample(mk_beat(1'b0), 1'b1, 4'b0001, 4'b0000);
        commit();
        reset = 1'b1;
        sample('0, 1'b0, 4'b0000, 4'b0000);
        checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_valid got %b want 0000", o_valid); end
        commit();
        reset = 1'b0;
        b = mk_beat(1'b1);
        sample(b, 1'b1, 4'b1000, 4'b1111);
        commit();
        sample('0, 1'b0, 4'b0000, 4'b1111);
        checks++; if (o_valid !== 4'b1000) begin errors++; $display("FAIL rstmid_route got %b want 1000", o_valid); end
        checks++; if (o_data !== b) begin errors++; $display("FAIL rstmid_data got %h want %h", o_data, b); end
        commit();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            sample(mk_beat(($urandom() % 3) == 0), ($urandom() % 10) < 7,
                   RADIX'($urandom()), RADIX'($urandom()));
            checks++; if (o_valid !== exp_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", i, o_valid, exp_valid); end
            checks++; if (o_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", i, o_ready, exp_ready); end
            if (exp_valid != '0) begin
                checks++; if (o_data !== exp_data) begin errors++; $display("FAIL rand_data cyc %0d got %h want %h", i, o_data, exp_data); end
            end
            commit();
        end
    endtask

    initial begin
        reset = 1'b1; i_data = '0; i_valid = 1'b0; i_mask = '0; i_ready = '0;
        in_pkt = 0; pkt_mask = '0;
        @(negedge clk);
        test_reset();
        test_unicast();
        test_packet_lock();
        test_staggered();
        test_null_mask();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
